// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing constants, colour/address widths and the
// timing bundle that travels alongside each pixel through the pipeline.
package vga_pkg;

  localparam int H_TOTAL  = 1056;
  localparam int V_TOTAL  = 628;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  localparam int CNT_W    = 11;
  localparam int RGB_W    = 12;
  localparam int ADDR_X_W = 6;
  localparam int ADDR_Y_W = 6;
  localparam int ADDR_W   = ADDR_X_W + ADDR_Y_W;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic             hsync;
    logic             hblnk;
    logic [CNT_W-1:0] vcount;
    logic             vsync;
    logic             vblnk;
  } vga_timing_t;

  localparam int TIMING_W = $bits(vga_timing_t);

endpackage

// File: rtl/vga_delay.sv
// N-cycle shift register used to keep the timing bundle aligned with the
// pixel data as it moves through the pipeline.
module vga_delay #(
  parameter int N = 1,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[N-1];

endmodule

// File: rtl/draw_img_rom_rd.sv
// Overlays a ROM image at a vsync-latched position onto the video stream.
// Define IMG_TRANSPARENT_EN to colour-key KEY_RGB pixels to the background.
module draw_img_rom_rd
  import vga_pkg::*;
#(
  parameter int         IMG_W   = 48,
  parameter int         IMG_H   = 64,
  parameter logic [11:0] KEY_RGB = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [CNT_W-1:0]  vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [RGB_W-1:0]  rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [CNT_W-1:0]  hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [CNT_W-1:0]  vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  vga_timing_t tim_in, tim_d1, tim_d2;
  logic [11:0] xq, yq;
  logic        vsync_prev;
  logic [12:0] h13, v13, xq13, yq13;
  logic        in_win, in_win_d1;
  logic [RGB_W-1:0] rgb_in_d1;

  assign tim_in = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};

  vga_delay #(.N(1), .W(TIMING_W)) u_dly1 (
    .clk  (clk),
    .rst  (rst),
    .din  (tim_in),
    .dout (tim_d1)
  );

  vga_delay #(.N(1), .W(TIMING_W)) u_dly2 (
    .clk  (clk),
    .rst  (rst),
    .din  (tim_d1),
    .dout (tim_d2)
  );

  assign hcount_out = tim_d2.hcount;
  assign hsync_out  = tim_d2.hsync;
  assign hblnk_out  = tim_d2.hblnk;
  assign vcount_out = tim_d2.vcount;
  assign vsync_out  = tim_d2.vsync;
  assign vblnk_out  = tim_d2.vblnk;

  // Position only moves on a rising vsync so a frame is never torn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_prev <= 1'b0;
      xq         <= '0;
      yq         <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in && !vsync_prev) begin
        xq <= xpos;
        yq <= ypos;
      end
    end
  end

  assign h13  = {2'b00, hcount_in};
  assign v13  = {2'b00, vcount_in};
  assign xq13 = {1'b0, xq};
  assign yq13 = {1'b0, yq};

  assign in_win = (h13 >= xq13) && (h13 < xq13 + 13'(IMG_W)) &&
                  (v13 >= yq13) && (v13 < yq13 + 13'(IMG_H));

  // Only the low 6 bits of each offset are needed, and those depend only on
  // the low 6 bits of the operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_addr <= '0;
      in_win_d1  <= 1'b0;
      rgb_in_d1  <= '0;
    end else begin
      pixel_addr <= in_win ? {vcount_in[5:0] - yq[5:0], hcount_in[5:0] - xq[5:0]}
                           : '0;
      in_win_d1  <= in_win;
      rgb_in_d1  <= rgb_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_out <= '0;
    end else if (tim_d1.hblnk || tim_d1.vblnk) begin
      rgb_out <= '0;
    end else if (in_win_d1) begin
`ifdef IMG_TRANSPARENT_EN
      rgb_out <= (rgb_pixel == KEY_RGB) ? rgb_in_d1 : rgb_pixel;
`else
      rgb_out <= rgb_pixel;
`endif
    end else begin
      rgb_out <= rgb_in_d1;
    end
  end

endmodule

// File: tb/tb_draw_img_rom_rd.sv
// Randomised bench for draw_img_rom_rd against a frame-level reference model.
module tb_draw_img_rom_rd;

  localparam int IMG_W = 48;
  localparam int IMG_H = 64;
  localparam logic [11:0] KEY = 12'h000;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos, rgb_pixel, pixel_addr;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [11:0] rom [4096];

  typedef struct {
    int          hc;
    int          vc;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
    logic        win;
    logic [11:0] addr;
  } rec_t;

  rec_t prev;
  int   mxq, myq;
  logic mvprev;
  int   test_count = 0;
  int   fail_count = 0;

  always #5 clk = ~clk;

  // The ROM's output register is the DUT's pixel_addr flop.
  assign rgb_pixel = rom[pixel_addr];

  draw_img_rom_rd #(.IMG_W(IMG_W), .IMG_H(IMG_H), .KEY_RGB(KEY)) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .rgb_pixel  (rgb_pixel),
    .pixel_addr (pixel_addr),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [11:0] imagePixel(input logic [11:0] rp, input logic [11:0] bg);
`ifdef IMG_TRANSPARENT_EN
    return (rp == KEY) ? bg : rp;
`else
    return rp;
`endif
  endfunction

  // One clock: model what the DUT sampled, then compare both pipeline stages.
  task automatic runCycle();
    rec_t        r;
    logic [11:0] exp_rgb;
    @(posedge clk);
    r.hc  = int'(hcount_in);
    r.vc  = int'(vcount_in);
    r.hs  = hsync_in;
    r.hb  = hblnk_in;
    r.vs  = vsync_in;
    r.vb  = vblnk_in;
    r.rgb = rgb_in;
    r.win = (r.hc >= mxq) && (r.hc < mxq + IMG_W) && (r.vc >= myq) && (r.vc < myq + IMG_H);
    r.addr = r.win ? 12'((r.vc - myq) * 64 + (r.hc - mxq)) : 12'h000;
    if (prev.hb || prev.vb)
      exp_rgb = 12'h000;
    else if (prev.win)
      exp_rgb = imagePixel(rom[prev.addr], prev.rgb);
    else
      exp_rgb = prev.rgb;
    if (r.vs && !mvprev) begin
      mxq = int'(xpos);
      myq = int'(ypos);
    end
    mvprev = r.vs;
    #1;
    checkOutput("pixel_addr", 32'(pixel_addr), 32'(r.addr));
    checkOutput("hcount_out", 32'(hcount_out), 32'(prev.hc));
    checkOutput("vcount_out", 32'(vcount_out), 32'(prev.vc));
    checkOutput("sync_blnk", {28'h0, hsync_out, hblnk_out, vsync_out, vblnk_out},
                {28'h0, prev.hs, prev.hb, prev.vs, prev.vb});
    checkOutput("rgb_out", 32'(rgb_out), 32'(exp_rgb));
    prev = r;
  endtask

  task automatic applyStimulus(input int hc, input int vc, input logic hs, input logic hb,
                               input logic vs, input logic vb, input logic [11:0] rgb,
                               input logic [11:0] xp, input logic [11:0] yp);
    hcount_in = 11'(hc);
    vcount_in = 11'(vc);
    hsync_in  = hs;
    hblnk_in  = hb;
    vsync_in  = vs;
    vblnk_in  = vb;
    rgb_in    = rgb;
    xpos      = xp;
    ypos      = yp;
    runCycle();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_addr", 32'(pixel_addr), 32'h0);
    checkOutput("rst_rgb", 32'(rgb_out), 32'h0);
    checkOutput("rst_counts", {10'h0, hcount_out, vcount_out}, 32'h0);
    checkOutput("rst_sync", {28'h0, hsync_out, hblnk_out, vsync_out, vblnk_out}, 32'h0);
    prev   = '{default: 0};
    mxq    = 0;
    myq    = 0;
    mvprev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hold_addr", 32'(pixel_addr), 32'h0);
    checkOutput("rst_hold_rgb", 32'(rgb_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic randomCycles(input int n);
    logic vs = vsync_in;
    for (int i = 0; i < n; i++) begin
      int hc, vc;
      logic [11:0] xp, yp;
      if ($urandom_range(0, 39) == 0) vs = ~vs;
      if ($urandom_range(0, 1) == 1) hc = mxq + int'($urandom_range(0, IMG_W + 9)) - 5;
      else hc = int'($urandom_range(0, 1055));
      if ($urandom_range(0, 1) == 1) vc = myq + int'($urandom_range(0, IMG_H + 9)) - 5;
      else vc = int'($urandom_range(0, 627));
      if (hc < 0) hc = 0;
      if (hc > 2047) hc = 2047;
      if (vc < 0) vc = 0;
      if (vc > 2047) vc = 2047;
      case ($urandom_range(0, 7))
        0:       begin xp = 12'd1040; yp = 12'd600; end
        1:       begin xp = 12'($urandom_range(0, 4095)); yp = 12'($urandom_range(0, 4095)); end
        2:       begin xp = 12'd0; yp = 12'd0; end
        default: begin xp = 12'($urandom_range(0, 1100)); yp = 12'($urandom_range(0, 650)); end
      endcase
      applyStimulus(hc, vc, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    vs, ($urandom_range(0, 9) == 0), 12'($urandom_range(0, 4095)), xp, yp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++)
      rom[i] = (i % 16 == 3) ? KEY : 12'($urandom_range(1, 4095));
    rom[12'h000] = 12'hF00;
    rom[12'h001] = KEY;
    rom[12'hFEF] = 12'h5A5;

    rst = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 0;
    vsync_in = 0; vblnk_in = 0; rgb_in = '0; xpos = '0; ypos = '0;
    #2;
    doReset();

    applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 12'd100, 12'd50);
    applyStimulus(0, 0, 0, 0, 1, 0, 12'h000, 12'd100, 12'd50);
    applyStimulus(100, 50, 0, 0, 1, 0, 12'h123, 12'd100, 12'd50);
    checkOutput("addr_origin", 32'(pixel_addr), 32'h000);
    applyStimulus(147, 113, 0, 0, 1, 0, 12'h456, 12'd100, 12'd50);
    checkOutput("rgb_origin", 32'(rgb_out), 32'hF00);
    checkOutput("addr_last", 32'(pixel_addr), 32'hFEF);
    applyStimulus(148, 113, 0, 0, 1, 0, 12'h789, 12'd100, 12'd50);
    checkOutput("rgb_last", 32'(rgb_out), 32'h5A5);
    checkOutput("addr_outside", 32'(pixel_addr), 32'h000);
    applyStimulus(101, 51, 0, 0, 1, 0, 12'h321, 12'd300, 12'd50);
    checkOutput("rgb_outside", 32'(rgb_out), 32'h789);
    checkOutput("addr_hold", 32'(pixel_addr), 32'h041);
    applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 12'd300, 12'd50);
    applyStimulus(0, 0, 0, 0, 1, 0, 12'h000, 12'd300, 12'd50);
    applyStimulus(301, 51, 0, 0, 1, 0, 12'h000, 12'd300, 12'd50);
    checkOutput("addr_moved", 32'(pixel_addr), 32'h041);
    applyStimulus(101, 51, 0, 0, 1, 0, 12'h000, 12'd300, 12'd50);
    checkOutput("addr_old_gone", 32'(pixel_addr), 32'h000);
    applyStimulus(300, 50, 0, 1, 1, 0, 12'hFFF, 12'd300, 12'd50);
    applyStimulus(301, 50, 0, 0, 1, 0, 12'h0AF, 12'd300, 12'd50);
    checkOutput("rgb_hblnk", 32'(rgb_out), 32'h000);
    applyStimulus(0, 0, 0, 0, 1, 0, 12'h000, 12'd300, 12'd50);
`ifdef IMG_TRANSPARENT_EN
    checkOutput("rgb_key", 32'(rgb_out), 32'h0AF);
`else
    checkOutput("rgb_key", 32'(rgb_out), 32'h000);
`endif

    randomCycles(1500);
    doReset();
    randomCycles(1500);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/draw_img_rom_rd.md
Name: draw_img_rom_rd

Overview:
- Reader side of the image ROM. Sits inline in the VGA pixel pipeline between the timing generator and the sync/output stage.
- Overlays a 48x64 image at a movable position. It issues 12-bit pixel addresses {addry[5:0], addrx[5:0]} to a registered 1-cycle-latency ROM and merges the returned rgb into the passing video stream.
- All timing signals are re-aligned to the ROM latency.

Parameters:
- IMG_W, 48, image width in pixels (addrx range 0..IMG_W-1)
- IMG_H, 64, image height in pixels (addry range 0..IMG_H-1)
- KEY_RGB, 12'h000, transparent colour key (used only with the optional feature)

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous reset, active-low
- hcount_in  input  11  horizontal pixel counter
- hsync_in  input  1  horizontal sync
- hblnk_in  input  1  horizontal blanking
- vcount_in  input  11  vertical line counter
- vsync_in  input  1  vertical sync
- vblnk_in  input  1  vertical blanking
- rgb_in  input  12  background pixel {r,g,b} 4 bits each
- xpos  input  12  requested image left edge
- ypos  input  12  requested image top edge
- rgb_pixel  input  12  ROM data, valid 1 cycle after pixel_addr
- pixel_addr  output  12  ROM address {addry[5:0], addrx[5:0]}
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  output  11/1/1/11/1/1  timing delayed by 2 cycles
- rgb_out  output  12  merged pixel

Behaviour:
- Reset (rst=0, asynchronous): all outputs, pipeline registers, xq/yq and vsync_prev cleared to 0.
- Position latch: register vsync_prev. On a rising vsync_in edge (vsync_in=1, vsync_prev=0), latch xq<=xpos and yq<=ypos. The position never changes mid-frame. A reset mid-frame leaves xq=yq=0 until the next vsync edge.
- Window test (stage 1, combinational on inputs):
  - in_win = (hcount_in >= xq) && (hcount_in < xq+IMG_W) && (vcount_in >= yq) && (vcount_in < yq+IMG_H).
  - Compute in 13-bit arithmetic so xq+IMG_W cannot wrap.
- Stage 1 register (cycle N+1):
  - pixel_addr <= {(vcount_in-yq)[5:0], (hcount_in-xq)[5:0]} when in_win, else 0.
  - in_win_d1 <= in_win.
  - All timing and rgb_in delayed 1 cycle.
- Stage 2 register (cycle N+2):
  - All timing delayed again, total latency 2 cycles.
  - rgb_out <= 0 if hblnk_d1|vblnk_d1.
  - Otherwise rgb_pixel if in_win_d1.
  - Otherwise rgb_in_d1.
- Latency: exactly 2 clk from any input sample to the matching outputs, including the first cycle after reset release.
- Boundaries:
  - Image partially off-screen: clipped naturally, and pixel_addr stays inside its valid range.
  - xq=0 or yq=0: the window starts at pixel 0.
  - A window touching blanking regions is still forced to black there.

Optional Feature:
- Macro IMG_TRANSPARENT_EN.
- Defined: in stage 2, when in_win_d1 and rgb_pixel==KEY_RGB, output rgb_in_d1 instead of rgb_pixel, so the image is colour-keyed over the background.
- Undefined: KEY_RGB is ignored and every in-window pixel comes from ROM.
- Latency is identical in both builds.

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants: H_TOTAL 1056, V_TOTAL 628, H_ACTIVE 800, V_ACTIVE 600.
  - Colour width 12 and address field widths 6/6.
- One natural sub-module: vga_delay, a parameterised N-cycle shift register for the timing bundle. Instantiate it twice (1 cycle each) or once with N=2 plus tap.

Test Plan:
- Reset asserted mid-line with rst=0 -> all outputs 0 immediately. After release, outputs track inputs 2 cycles later with xq=yq=0.
- xpos=100, ypos=50 latched at a vsync edge; hcount_in=100, vcount_in=50 -> pixel_addr=12'h000 at N+1; ROM returns 12'hF00 -> rgb_out=12'hF00 at N+2.
- hcount_in=147, vcount_in=113 (last pixel) -> pixel_addr={6'd63,6'd47}=12'hFEF. hcount_in=148 -> rgb_out=rgb_in delayed, pixel_addr=0.
- xpos changed to 300 mid-frame -> window stays at 100 until the next rising vsync_in, then moves to 300.
- Window overlapping hblnk_in=1 -> rgb_out=0 regardless of rgb_pixel.
- IMG_TRANSPARENT_EN defined, KEY_RGB=12'h000, rgb_pixel=12'h000, rgb_in=12'h0AF -> rgb_out=12'h0AF. Undefined -> rgb_out=12'h000.
